// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART link controller: TX FSM states, frame codes
// and the helper that maps a frame selection and byte index to the byte on the wire.
package uart_link_pkg;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_LOAD    = 2'd1,
        TX_WAIT_HI = 2'd2,
        TX_WAIT_LO = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        SEL_ACK   = 2'd0,
        SEL_DONE  = 2'd1,
        SEL_NONCE = 2'd2
    } frame_sel_e;

    localparam logic [7:0]  FRAME_ACK   = 8'hA5;
    localparam logic [7:0]  FRAME_NONCE = 8'h4E;
    localparam logic [7:0]  FRAME_DONE  = 8'h58;
    localparam int unsigned NONCE_BYTES = 4;

    function automatic logic [7:0] frame_byte(input frame_sel_e sel,
                                              input logic [2:0] idx,
                                              input logic [31:0] nonce);
        logic [7:0] b;
        b = 8'h00;
        case (sel)
            SEL_ACK:  b = FRAME_ACK;
            SEL_DONE: b = FRAME_DONE;
            SEL_NONCE: begin
                case (idx)
                    3'd0:    b = FRAME_NONCE;
                    3'd1:    b = nonce[31:24];
                    3'd2:    b = nonce[23:16];
                    3'd3:    b = nonce[15:8];
                    3'd4:    b = nonce[7:0];
                    default: b = 8'h00;
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Index of the final byte of a frame.
    function automatic logic [2:0] frame_last(input frame_sel_e sel);
        logic [2:0] last;
        case (sel)
            SEL_NONCE: last = 3'(NONCE_BYTES);
            default:   last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/uart_link_ctrl_header_assembler.sv
// Receive-side block header assembly: takes bytes from the UART receiver, builds
// a header MSB-first in a shadow register and publishes it once complete.
module header_assembler
    import uart_link_pkg::*;
#(
    parameter int unsigned HEADER_BYTES = 80,
    parameter int unsigned GAP_CYCLES   = 5_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_rdy,
    output logic                      rdy_clr,
    output logic [8*HEADER_BYTES-1:0] header_out,
    output logic                      header_valid
);

    localparam int unsigned HW    = 8 * HEADER_BYTES;
    localparam int unsigned CNT_W = $clog2(HEADER_BYTES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(HEADER_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    // Only the first HEADER_BYTES-1 bytes need holding; the last arrives on rx_data.
    logic [HW-9:0]      shadow_q,       shadow_d;
    logic [HW-1:0]      header_q,       header_d;
    logic               header_valid_q, header_valid_d;
    logic               rdy_clr_q,      rdy_clr_d;
    logic [CNT_W-1:0]   byte_cnt_q,     byte_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q,      gap_cnt_d;
    logic               accept_s;

    // Byte acceptance, shadow shift, header publish and inter-byte timeout.
    always_comb begin
        accept_s       = rx_rdy && !rdy_clr_q;
        rdy_clr_d      = accept_s;
        shadow_d       = shadow_q;
        header_d       = header_q;
        header_valid_d = 1'b0;
        byte_cnt_d     = byte_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        if (accept_s) begin
            shadow_d  = {shadow_q[HW-17:0], rx_data};
            gap_cnt_d = '0;
            if (byte_cnt_q == LAST_BYTE) begin
                header_d       = {shadow_q, rx_data};
                header_valid_d = 1'b1;
                byte_cnt_d     = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end else if (byte_cnt_q != '0) begin
            if (gap_cnt_q == GAP_LAST) begin
                byte_cnt_d = '0;
                gap_cnt_d  = '0;
            end else begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
        end else begin
            gap_cnt_d = '0;
        end
    end

    // Receive-side state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q       <= '0;
            header_q       <= '0;
            header_valid_q <= 1'b0;
            rdy_clr_q      <= 1'b0;
            byte_cnt_q     <= '0;
            gap_cnt_q      <= '0;
        end else begin
            shadow_q       <= shadow_d;
            header_q       <= header_d;
            header_valid_q <= header_valid_d;
            rdy_clr_q      <= rdy_clr_d;
            byte_cnt_q     <= byte_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign rdy_clr      = rdy_clr_q;
    assign header_out   = header_q;
    assign header_valid = header_valid_q;

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: header reception plus a prioritised reply transmitter
// reporting header ACKs, found nonces and search completion to the host.
module uart_link_ctrl
    import uart_link_pkg::*;
#(
    parameter int unsigned HEADER_BYTES = 80,
    parameter int unsigned GAP_CYCLES   = 5_000_000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_rdy,
    output logic                      rdy_clr,
    output logic [7:0]                tx_data,
    output logic                      tx_wr_en,
    input  logic                      tx_busy,
    output logic [8*HEADER_BYTES-1:0] header_out,
    output logic                      header_valid,
    input  logic [31:0]               nonce_in,
    input  logic                      nonce_found,
    input  logic                      search_done,
    output logic                      overrun
);

    tx_state_e   state_q,       state_d;
    frame_sel_e  sel_q,         sel_d;
    logic [2:0]  idx_q,         idx_d;
    logic [31:0] nonce_q,       nonce_d;
    logic [31:0] frame_nonce_q, frame_nonce_d;
    logic        ack_pend_q,    ack_pend_d;
    logic        done_pend_q,   done_pend_d;
    logic        nonce_pend_q,  nonce_pend_d;
    logic        overrun_q,     overrun_d;
    logic [7:0]  tx_data_q,     tx_data_d;
    logic        tx_wr_en_q,    tx_wr_en_d;
    logic        ack_clr_s,     done_clr_s,  nonce_clr_s;
    logic        any_pend_s;

    header_assembler #(
        .HEADER_BYTES (HEADER_BYTES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_header_assembler (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .rdy_clr      (rdy_clr),
        .header_out   (header_out),
        .header_valid (header_valid)
    );

    // TX FSM next state; the in-flight nonce is frozen when byte 0 is issued.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        idx_d         = idx_q;
        frame_nonce_d = frame_nonce_q;
        ack_clr_s     = 1'b0;
        done_clr_s    = 1'b0;
        nonce_clr_s   = 1'b0;
        any_pend_s    = nonce_pend_q || done_pend_q || ack_pend_q;
        case (state_q)
            TX_IDLE: begin
                if (any_pend_s && !tx_busy) begin
                    state_d = TX_LOAD;
                    idx_d   = 3'd0;
                    if (nonce_pend_q) begin
                        sel_d = SEL_NONCE;
                    end else if (done_pend_q) begin
                        sel_d = SEL_DONE;
                    end else begin
                        sel_d = SEL_ACK;
                    end
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_LOAD: begin
                state_d = TX_WAIT_HI;
                if (idx_q == 3'd0) begin
                    case (sel_q)
                        SEL_NONCE: begin
                            nonce_clr_s   = 1'b1;
                            frame_nonce_d = nonce_q;
                        end
                        SEL_DONE: done_clr_s = 1'b1;
                        SEL_ACK:  ack_clr_s  = 1'b1;
                        default:  ack_clr_s  = 1'b0;
                    endcase
                end else begin
                    frame_nonce_d = frame_nonce_q;
                end
            end
            TX_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = TX_WAIT_LO;
                end else begin
                    state_d = TX_WAIT_HI;
                end
            end
            TX_WAIT_LO: begin
                if (tx_busy) begin
                    state_d = TX_WAIT_LO;
                end else if (idx_q == frame_last(sel_q)) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_LOAD;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Registered TX outputs: the write strobe is high exactly while in TX_LOAD.
    always_comb begin
        tx_wr_en_d = (state_d == TX_LOAD);
        if (state_d == TX_LOAD) begin
            tx_data_d = frame_byte(sel_d, idx_d, frame_nonce_q);
        end else begin
            tx_data_d = tx_data_q;
        end
    end

    // Pending requests: a new pulse wins over a same-cycle clear.
    always_comb begin
        ack_pend_d   = header_valid || (ack_pend_q && !ack_clr_s);
        done_pend_d  = search_done  || (done_pend_q && !done_clr_s);
        nonce_pend_d = nonce_found  || (nonce_pend_q && !nonce_clr_s);
        if (nonce_found) begin
            nonce_d = nonce_in;
        end else begin
            nonce_d = nonce_q;
        end
        overrun_d = overrun_q || (nonce_found && nonce_pend_q && !nonce_clr_s);
    end

    // Transmit-side state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= TX_IDLE;
            sel_q         <= SEL_ACK;
            idx_q         <= 3'd0;
            nonce_q       <= 32'h0000_0000;
            frame_nonce_q <= 32'h0000_0000;
            ack_pend_q    <= 1'b0;
            done_pend_q   <= 1'b0;
            nonce_pend_q  <= 1'b0;
            overrun_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_wr_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            nonce_q       <= nonce_d;
            frame_nonce_q <= frame_nonce_d;
            ack_pend_q    <= ack_pend_d;
            done_pend_q   <= done_pend_d;
            nonce_pend_q  <= nonce_pend_d;
            overrun_q     <= overrun_d;
            tx_data_q     <= tx_data_d;
            tx_wr_en_q    <= tx_wr_en_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_wr_en = tx_wr_en_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: header reception, reply framing, priority,
// overrun, transmitter back-pressure and mid-frame reset.
module tb_uart_link_ctrl;

    localparam int HB  = 80;
    localparam int GAP = 200;

    logic            clock = 1'b0;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_rdy;
    logic            rdy_clr;
    logic [7:0]      tx_data;
    logic            tx_wr_en;
    logic            tx_busy = 1'b0;
    logic [8*HB-1:0] header_out;
    logic            header_valid;
    logic [31:0]     nonce_in;
    logic            nonce_found;
    logic            search_done;
    logic            overrun;

    int n_checks = 0;
    int n_errs   = 0;
    int hv_cnt   = 0;
    int rc_cnt   = 0;
    int busy_viol = 0;
    int busy_cnt = 0;
    int busy_len = 3;
    logic [7:0]      txq[$];
    logic [7:0]      exp_q[$];
    logic [8*HB-1:0] exp_hdr;

    uart_link_ctrl #(.HEADER_BYTES(HB), .GAP_CYCLES(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_rdy       (rx_rdy),
        .rdy_clr      (rdy_clr),
        .tx_data      (tx_data),
        .tx_wr_en     (tx_wr_en),
        .tx_busy      (tx_busy),
        .header_out   (header_out),
        .header_valid (header_valid),
        .nonce_in     (nonce_in),
        .nonce_found  (nonce_found),
        .search_done  (search_done),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // Transmitter model and event monitor, sampled just after each rising edge.
    always @(posedge clock) begin
        #1;
        if (tx_wr_en) begin
            if (tx_busy) busy_viol++;
            txq.push_back(tx_data);
            busy_cnt = busy_len;
            tx_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (header_valid) hv_cnt++;
        if (rdy_clr) rc_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (rdy_clr) seen = 1'b1;
        end
        rx_rdy = 1'b0;
        if (!seen) chk("rx_handshake", 64'd0, 64'd1);
        repeat (gap) @(posedge clock);
    endtask

    task automatic pulse_nonce(input logic [31:0] v, input logic with_done);
        @(negedge clock);
        nonce_in    = v;
        nonce_found = 1'b1;
        search_done = with_done;
        @(negedge clock);
        nonce_found = 1'b0;
        search_done = 1'b0;
    endtask

    // Waits for the expected byte count, lets the line settle, then compares bytes.
    task automatic wait_tx(input string tag, input int base, input int budget);
        int t;
        t = 0;
        while ((txq.size() - base) < exp_q.size() && t < budget) begin
            @(negedge clock);
            t++;
        end
        repeat (2 * busy_len + 30) @(negedge clock);
        chk({tag, "_count"}, 64'(txq.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (base + i < txq.size()) ? 64'(txq[base + i]) : 64'hFFFF, 64'(exp_q[i]));
        end
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hv0;
        int rc0;
        int v0;
        int t;
        reset = 1'b1; rx_data = 8'h00; rx_rdy = 1'b0;
        nonce_in = 32'h0; nonce_found = 1'b0; search_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_wr_en",   64'(tx_wr_en), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_rdy_clr", 64'(rdy_clr), 64'd0);
        chk("rst_hv",      64'(header_valid), 64'd0);
        chk("rst_hdr",     64'(header_out == '0), 64'd1);
        chk("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;

        // 80-byte header with 10-cycle gaps, then the ACK
        base = txq.size(); hv0 = hv_cnt; rc0 = rc_cnt;
        for (int i = 0; i < HB; i++) send_byte(8'(i), 10);
        for (int i = 0; i < HB; i++) exp_hdr[8*HB-1-8*i -: 8] = 8'(i);
        chk("a_hv_count", 64'(hv_cnt - hv0), 64'd1);
        chk("a_rdy_clr",  64'(rc_cnt - rc0), 64'(HB));
        chk("a_hdr_top",  64'(header_out[8*HB-1 -: 8]), 64'h00);
        chk("a_hdr_bot",  64'(header_out[7:0]), 64'h4F);
        chk("a_hdr_all",  64'(header_out == exp_hdr), 64'd1);
        exp_q = '{8'hA5};
        wait_tx("a_tx", base, 2000);

        // partial header abandoned by the gap timeout
        base = txq.size(); hv0 = hv_cnt;
        for (int i = 0; i < 40; i++) send_byte(8'(192 + i), 10);
        repeat (GAP + 1) @(negedge clock);
        chk("b_hdr_hold", 64'(header_out == exp_hdr), 64'd1);
        for (int i = 0; i < HB; i++) send_byte(8'(32 + i), 10);
        for (int i = 0; i < HB; i++) exp_hdr[8*HB-1-8*i -: 8] = 8'(32 + i);
        chk("b_hv_count", 64'(hv_cnt - hv0), 64'd1);
        chk("b_hdr_all",  64'(header_out == exp_hdr), 64'd1);
        exp_q = '{8'hA5};
        wait_tx("b_tx", base, 2000);

        // nonce arriving together with the ACK takes priority
        base = txq.size();
        for (int i = 0; i < HB - 1; i++) send_byte(8'(3 * i), 4);
        send_byte(8'h77, 0);
        nonce_in = 32'h1234_5678; nonce_found = 1'b1;
        @(posedge clock);
        #1;
        nonce_found = 1'b0;
        exp_q = '{8'h4E, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5};
        wait_tx("c_tx", base, 500);
        chk("c_overrun", 64'(overrun), 64'd0);

        // back-to-back nonces before the frame starts
        base = txq.size();
        @(negedge clock);
        nonce_in = 32'h1111_1111; nonce_found = 1'b1;
        @(negedge clock);
        nonce_in = 32'h2222_2222;
        @(negedge clock);
        nonce_found = 1'b0;
        exp_q = '{8'h4E, 8'h22, 8'h22, 8'h22, 8'h22};
        wait_tx("d_tx", base, 500);
        chk("d_overrun", 64'(overrun), 64'd1);

        // new nonce during a frame, with DONE pending behind it
        base = txq.size();
        pulse_nonce(32'hAABB_CCDD, 1'b1);
        repeat (6) @(negedge clock);
        pulse_nonce(32'h0102_0304, 1'b0);
        exp_q = '{8'h4E, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                  8'h4E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h58};
        wait_tx("e_tx", base, 1000);

        // long transmitter busy periods
        busy_len = 1000;
        base = txq.size(); v0 = busy_viol;
        pulse_nonce(32'hCAFE_F00D, 1'b0);
        exp_q = '{8'h4E, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        wait_tx("f_tx", base, 8000);
        chk("f_busy_viol", 64'(busy_viol - v0), 64'd0);
        busy_len = 3;
        repeat (20) @(negedge clock);

        // reset after the second byte of a nonce frame
        base = txq.size();
        pulse_nonce(32'h9ABC_DEF0, 1'b0);
        t = 0;
        while ((txq.size() - base) < 2 && t < 200) begin
            @(negedge clock);
            t++;
        end
        reset = 1'b1;
        #1;
        chk("g_sent_before", 64'(txq.size() - base), 64'd2);
        chk("g_wr_en",   64'(tx_wr_en), 64'd0);
        chk("g_tx_data", 64'(tx_data), 64'd0);
        chk("g_overrun", 64'(overrun), 64'd0);
        chk("g_hdr",     64'(header_out == '0), 64'd1);
        chk("g_hv",      64'(header_valid), 64'd0);
        chk("g_rdy_clr", 64'(rdy_clr), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        chk("g_no_resume", 64'(txq.size() - base), 64'd2);
        chk("g_idle_wr",   64'(tx_wr_en), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/uart_link_ctrl.md
UART_LINK_CTRL -- requirements
Module: uart_link_ctrl

Interface
REQ-001 SHALL have parameter HEADER_BYTES, default 80, bytes per block header.
REQ-002 SHALL have parameter GAP_CYCLES, default 5_000_000, inter-byte timeout in clock cycles (100 ms at 50 MHz).
REQ-003 SHALL have port clock  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_data  in  8  byte from the UART receiver.
REQ-006 SHALL have port rx_rdy  in  1  UART receiver byte-ready level.
REQ-007 SHALL have port rdy_clr  out  1  one-cycle clear of rx_rdy.
REQ-008 SHALL have port tx_data  out  8  byte to the UART transmitter.
REQ-009 SHALL have port tx_wr_en  out  1  one-cycle write strobe.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port header_out  out  8*HEADER_BYTES  last complete header.
REQ-012 SHALL have port header_valid  out  1  one-cycle pulse when header_out updates.
REQ-013 SHALL have port nonce_in  in  32  nonce from the miner core.
REQ-014 SHALL have port nonce_found  in  1  one-cycle pulse; nonce_in valid in the same cycle.
REQ-015 SHALL have port search_done  in  1  one-cycle pulse; nonce space exhausted.
REQ-016 SHALL have port overrun  out  1  sticky; a pending nonce was overwritten.

Function
REQ-017 SHALL accept a byte in the cycle rx_rdy is high and rdy_clr is low, then assert rdy_clr for exactly the next cycle.
REQ-018 SHALL assemble the header MSB-first: byte 0 lands in header_out[8*HEADER_BYTES-1 -: 8].
REQ-019 SHALL collect bytes in a shadow register and copy it to header_out only on the HEADER_BYTES-th byte; header_valid pulses in the cycle after that byte is accepted.
REQ-020 SHALL hold header_out stable between header_valid pulses.
REQ-021 SHALL discard a partial header and restart at byte 0 when GAP_CYCLES cycles pass with no accepted byte; the gap counter stops while idle at byte 0.
REQ-022 SHALL latch three pending requests: ACK on header completion, NONCE (capturing nonce_in) on nonce_found, DONE on search_done.
REQ-023 SHALL define frames ACK = 0xA5; DONE = 0x58; NONCE = 0x4E followed by nonce bytes [31:24], [23:16], [15:8], [7:0].
REQ-024 SHALL serve pending requests by fixed priority NONCE > DONE > ACK, chosen only in TX_IDLE; a frame is never interrupted.
REQ-025 SHALL implement TX FSM states TX_IDLE -> TX_LOAD (drive tx_data, tx_wr_en=1 for one cycle) -> TX_WAIT_HI (until tx_busy=1) -> TX_WAIT_LO (until tx_busy=0) -> TX_LOAD for the next byte, or TX_IDLE after the last byte.
REQ-026 SHALL advance TX_IDLE -> TX_LOAD on the cycle after a request becomes pending; it shall not assert tx_wr_en while tx_busy=1.
REQ-027 SHALL clear a request's pending flag in the cycle its TX_LOAD of byte 0 is issued.
REQ-028 SHALL overwrite the stored nonce and set overrun when nonce_found arrives while NONCE is pending; a nonce_found during an active NONCE frame sets a new pending without corrupting the frame in flight.
REQ-029 SHALL handle a pulse and a clear of the same flag in one cycle by leaving the flag set.
REQ-030 SHALL keep RX assembly independent of TX activity.

Reset
REQ-031 SHALL, on reset, immediately force rdy_clr=0, tx_wr_en=0, tx_data=0, header_valid=0, header_out=0, overrun=0, all pending flags clear, byte and gap counters at 0, and the FSM in TX_IDLE.
REQ-032 SHALL abandon any frame in progress when reset asserts mid-frame, with no resumption after release.

Structure
REQ-033 SHALL place the TX state enum, the frame codes 0xA5/0x4E/0x58, and the nonce byte count (4) in shared package uart_link_pkg.
REQ-034 SHALL implement RX assembly plus the gap timer as sub-module header_assembler; TX arbitration and the FSM stay in the top module.

Verification
REQ-035 SHALL show: 80 bytes 0x00..0x4F, gaps of 10 cycles -> header_valid once, header_out[639:632]=0x00, [7:0]=0x4F, then TX byte 0xA5.
REQ-036 SHALL show: 40 bytes, idle GAP_CYCLES+1 cycles, then 80 bytes -> one header_valid; header_out equals the second burst only.
REQ-037 SHALL show: nonce_found with nonce_in=0x12345678 while ACK is pending -> TX sequence 0x4E,0x12,0x34,0x56,0x78,0xA5.
REQ-038 SHALL show: two nonce_found pulses (0x11111111, then 0x22222222) before a frame starts -> one frame carrying 0x22222222 and overrun=1.
REQ-039 SHALL show: tx_busy held high 1000 cycles -> exactly one tx_wr_en pulse per byte, none while busy.
REQ-040 SHALL show: reset asserted after the second NONCE byte -> tx_wr_en=0 at once, no further bytes, all outputs at reset values.
